alu_feeder: RTL and testbench
=============================

Name: alu_feeder

Overview:
- Sequencer that drives the fully-connected ALU's load side: fetches the input-value vector once, then per neuron the bias+weight vector from word-addressed memory.
- Packs the fetched words onto the ALU's (INPUT_SZ+1)-word bus and strobes the ALU load codes.
- Captures the ALU's Q-format output as one result per neuron.
- Sits between layer memory and one ALU instance in the FC layer datapath.

Parameters:
- SIZE, 16, word width in bits (matches ALU SIZE).
- INPUT_SZ, 4, values per neuron; the bus carries INPUT_SZ+1 words.
- ADDR_W, 16, memory address width.
- CNT_W, 8, neuron counter width.

Ports:
- clk  in  1  clock, all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a layer when idle.
- num_neurons  in  CNT_W  neurons to process; sampled on start.
- v_base  in  ADDR_W  address of value word 0; sampled on start.
- w_base  in  ADDR_W  address of neuron 0 bias; sampled on start.
- mem_rd  out  1  read request, one-cycle pulse.
- mem_addr  out  ADDR_W  read address, valid with mem_rd.
- mem_rdata  in  SIZE  read data.
- mem_rvalid  in  1  mem_rdata valid; latency of 1 or more cycles.
- alu_values  out  (INPUT_SZ+1)*SIZE  packed bus; word 0 in the MSBs, word INPUT_SZ in the LSBs.
- alu_load_enable  out  2  0=LOAD_VALUES, 1=LOAD_BIAS_WEIGHTS, 2=idle.
- alu_enable  out  1  high while busy.
- alu_clear  out  1  ALU clear pulse.
- alu_value  in  SIZE  ALU result.
- result  out  SIZE  captured neuron output.
- result_valid  out  1  one-cycle pulse per neuron.
- result_idx  out  CNT_W  neuron index of result.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at layer end.

Behaviour:
- Reset values:
  - alu_load_enable=2'd2; never reset to 0, which is LOAD_VALUES.
  - All other outputs 0; assembly buffer 0; state IDLE.
- FSM states: IDLE, CLR, V_RD, V_WAIT, V_PUSH, W_RD, W_WAIT, W_PUSH, SETTLE, CAPTURE, DONE.
- IDLE:
  - On start, latch num_neurons, v_base and w_base; clear word and neuron counters; go to CLR.
  - start is ignored in every other state.
- CLR: alu_clear=1 for exactly one cycle, then V_RD.
- Memory access:
  - One outstanding read only.
  - *_RD: mem_rd=1 for one cycle, then *_WAIT.
  - *_WAIT: on mem_rvalid, store the word in buffer[k] and increment k.
  - mem_rvalid outside *_WAIT is ignored, including stale data after reset.
- Value fetch:
  - Reads addresses v_base+k for k=0..INPUT_SZ-1.
  - Buffer word INPUT_SZ is forced to 0.
  - After the last word, go to V_PUSH.
- V_PUSH: alu_values=buffer; alu_load_enable=0 for exactly one cycle. The ALU latches on negedge inside this cycle, so the bus is stable for the whole cycle.
- Zero neurons: if num_neurons==0 after V_PUSH, go straight to DONE.
- Weight fetch, neuron n:
  - Reads w_base + n*(INPUT_SZ+1) + k for k=0..INPUT_SZ.
  - Word 0 is the bias, words 1..INPUT_SZ are the weights.
  - Address computed in ADDR_W bits; wraps modulo 2^ADDR_W, no error.
- W_PUSH: alu_load_enable=1 for one cycle, then SETTLE.
- SETTLE: one idle cycle for the combinational accumulator.
- CAPTURE:
  - Registers result<=alu_value, result_idx<=n, result_valid=1 for one cycle.
  - If n==num_neurons-1 go to DONE; else n++, go to W_RD.
- DONE: done=1 for one cycle, then IDLE.
- Value reuse: values are loaded once per layer and reused across neurons. Weight loads do not disturb the ALU's value registers.
- alu_values holds its last driven contents between pushes.
- Latency, memory latency L:
  - Per neuron: (INPUT_SZ+1)*(L+1) + 3 cycles from W_RD entry to result_valid.
  - Value phase: 1 + INPUT_SZ*(L+1) + 1 cycles.
- Reset mid-operation: async return to the reset state. No done or result_valid pulse is produced, and the ALU is not touched beyond the load_enable idle code.

Test Plan:
- Basic run, INPUT_SZ=4, L=1, num_neurons=1:
  - Memory: values {1.0,2.0,0,0} = 0x0800,0x1000,0,0; bias 0x0400; weights {0x0800,0x0800,0,0}.
  - Required: result=0x1C00 (3.5), result_idx=0, one result_valid, done one cycle after CAPTURE.
- num_neurons=3, distinct biases 0x0800/0x1000/0x1800, all weights 0:
  - Results 0x0800, 0x1000, 0x1800 with idx 0,1,2.
  - Values read exactly once (4 reads); 15 weight reads in total.
- num_neurons=0: only 4 value reads, V_PUSH seen, done pulses, no result_valid.
- Variable latency L=1..5 with spurious mem_rvalid in W_PUSH:
  - Results identical to the L=1 run.
  - Spurious beats ignored.
  - alu_load_enable==1 for exactly one cycle per neuron.
- start re-pulsed while busy: no restart, result sequence unchanged.
- rst_n low during W_WAIT of neuron 1:
  - Immediately alu_load_enable=2, busy=0, no done.
  - Fresh start afterwards produces correct results.

Source files
------------

// File: rtl/alu_feeder.sv
// alu_feeder: fetches a layer's input values once, then each neuron's bias
// and weights, strobes them into the FC ALU and captures one result per neuron.
module alu_feeder #(
    parameter int SIZE     = 16,
    parameter int INPUT_SZ = 4,
    parameter int ADDR_W   = 16,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CNT_W-1:0]             num_neurons,
    input  logic [ADDR_W-1:0]            v_base,
    input  logic [ADDR_W-1:0]            w_base,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [SIZE-1:0]              mem_rdata,
    input  logic                         mem_rvalid,
    output logic [(INPUT_SZ+1)*SIZE-1:0] alu_values,
    output logic [1:0]                   alu_load_enable,
    output logic                         alu_enable,
    output logic                         alu_clear,
    input  logic [SIZE-1:0]              alu_value,
    output logic [SIZE-1:0]              result,
    output logic                         result_valid,
    output logic [CNT_W-1:0]             result_idx,
    output logic                         busy,
    output logic                         done
);
    localparam int NW = INPUT_SZ + 1;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [KW-1:0] K_LAST_V = KW'(INPUT_SZ - 1);
    localparam logic [KW-1:0] K_LAST_W = KW'(INPUT_SZ);
    localparam logic [ADDR_W-1:0] A_STRIDE = ADDR_W'(NW);
    localparam logic [1:0] LD_VALUES = 2'd0;
    localparam logic [1:0] LD_BW     = 2'd1;
    localparam logic [1:0] LD_IDLE   = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_V_RD, S_V_WAIT, S_V_PUSH,
        S_W_RD, S_W_WAIT, S_W_PUSH, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_n;
    logic [ADDR_W-1:0]   r_vbase;
    logic [ADDR_W-1:0]   r_wptr;
    logic [KW-1:0]       r_k;
    logic [SIZE-1:0]     r_buf [NW];
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [NW*SIZE-1:0]  r_alu_values;
    logic [1:0]          r_load;
    logic                r_clear;
    logic [SIZE-1:0]     r_result;
    logic                r_rvalid;
    logic [CNT_W-1:0]    r_idx;
    logic                r_done;

    logic [KW-1:0]       w_k_nxt;
    logic [ADDR_W-1:0]   w_wptr_nxt;
    logic                w_last_n;
    logic [NW*SIZE-1:0]  w_pack;

    assign w_k_nxt    = r_k + KW'(1);
    assign w_wptr_nxt = r_wptr + A_STRIDE;
    assign w_last_n   = (r_n == r_num - CNT_W'(1));

    // Bus image including the word arriving this cycle, so the push
    // register can be loaded on the same edge that stores the last word.
    always_comb begin
        w_pack = '0;
        for (int i = 0; i < NW; i++) begin
            w_pack[(NW-1-i)*SIZE +: SIZE] =
                (KW'(i) == r_k) ? mem_rdata : r_buf[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_num        <= '0;
            r_n          <= '0;
            r_vbase      <= '0;
            r_wptr       <= '0;
            r_k          <= '0;
            for (int i = 0; i < NW; i++) r_buf[i] <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_alu_values <= '0;
            r_load       <= LD_IDLE;
            r_clear      <= 1'b0;
            r_result     <= '0;
            r_rvalid     <= 1'b0;
            r_idx        <= '0;
            r_done       <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            r_load   <= LD_IDLE;
            r_clear  <= 1'b0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num   <= num_neurons;
                        r_vbase <= v_base;
                        r_wptr  <= w_base;
                        r_k     <= '0;
                        r_n     <= '0;
                        r_clear <= 1'b1;
                        r_state <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_buf[INPUT_SZ] <= '0;
                    r_mem_rd        <= 1'b1;
                    r_mem_addr      <= r_vbase;
                    r_state         <= S_V_RD;
                end
                S_V_RD: r_state <= S_V_WAIT;
                S_V_WAIT: begin
                    if (mem_rvalid) begin
                        r_buf[r_k] <= mem_rdata;
                        if (r_k == K_LAST_V) begin
                            r_alu_values <= w_pack;
                            r_load       <= LD_VALUES;
                            r_state      <= S_V_PUSH;
                        end else begin
                            r_k        <= w_k_nxt;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_vbase + ADDR_W'(w_k_nxt);
                            r_state    <= S_V_RD;
                        end
                    end
                end
                S_V_PUSH: begin
                    r_k <= '0;
                    if (r_num == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= r_wptr;
                        r_state    <= S_W_RD;
                    end
                end
                S_W_RD: r_state <= S_W_WAIT;
                S_W_WAIT: begin
                    if (mem_rvalid) begin
                        r_buf[r_k] <= mem_rdata;
                        if (r_k == K_LAST_W) begin
                            r_alu_values <= w_pack;
                            r_load       <= LD_BW;
                            r_state      <= S_W_PUSH;
                        end else begin
                            r_k        <= w_k_nxt;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= r_wptr + ADDR_W'(w_k_nxt);
                            r_state    <= S_W_RD;
                        end
                    end
                end
                S_W_PUSH: r_state <= S_SETTLE;
                S_SETTLE: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_result <= alu_value;
                    r_idx    <= r_n;
                    r_rvalid <= 1'b1;
                    if (w_last_n) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_n        <= r_n + CNT_W'(1);
                        r_wptr     <= w_wptr_nxt;
                        r_k        <= '0;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_wptr_nxt;
                        r_state    <= S_W_RD;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy            = (r_state != S_IDLE);
    assign alu_enable      = busy;
    assign mem_rd          = r_mem_rd;
    assign mem_addr        = r_mem_addr;
    assign alu_values      = r_alu_values;
    assign alu_load_enable = r_load;
    assign alu_clear       = r_clear;
    assign result          = r_result;
    assign result_valid    = r_rvalid;
    assign result_idx      = r_idx;
    assign done            = r_done;
endmodule

// File: tb/tb_alu_feeder.sv
// Scoreboard bench for alu_feeder: memory responder with variable latency,
// a Q4.11 ALU model, and expectations derived from memory contents.
module tb_alu_feeder;
    localparam int INPUT_SZ = 4;
    localparam int NW = INPUT_SZ + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_neurons = '0;
    logic [15:0] v_base = '0;
    logic [15:0] w_base = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [79:0] alu_values;
    logic [1:0]  alu_load_enable;
    logic        alu_enable;
    logic        alu_clear;
    logic [15:0] alu_value;
    logic [15:0] result;
    logic        result_valid;
    logic [7:0]  result_idx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    alu_feeder #(.SIZE(16), .INPUT_SZ(INPUT_SZ), .ADDR_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num_neurons(num_neurons), .v_base(v_base), .w_base(w_base),
        .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .alu_values(alu_values), .alu_load_enable(alu_load_enable),
        .alu_enable(alu_enable), .alu_clear(alu_clear),
        .alu_value(alu_value), .result(result),
        .result_valid(result_valid), .result_idx(result_idx),
        .busy(busy), .done(done)
    );

    logic [15:0] mem [65536];
    int  n_tests = 0;
    int  n_fail = 0;
    int  lat_fix = 1;
    bit  lat_rand = 1'b0;
    bit  spur_en = 1'b0;
    int  cyc = 0, t_start = 0, t_done = 0;
    int  rd_cnt = 0, load0_cnt = 0, load1_cnt = 0, done_cnt = 0;

    logic [15:0] q_addr[$];
    logic [15:0] q_res[$];
    logic [7:0]  q_idx[$];
    logic [79:0] q_vbus[$];

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // ALU: registers latch on negedge, accumulator is combinational
    logic signed [15:0] a_v [INPUT_SZ];
    logic signed [15:0] a_w [INPUT_SZ];
    logic signed [15:0] a_b = '0;
    int alu_acc;

    initial begin
        for (int k = 0; k < INPUT_SZ; k++) begin
            a_v[k] = '0;
            a_w[k] = '0;
        end
        forever begin
            @(negedge clk);
            if (alu_clear) begin
                a_b = '0;
                for (int k = 0; k < INPUT_SZ; k++) begin
                    a_v[k] = '0;
                    a_w[k] = '0;
                end
            end else if (alu_load_enable == 2'd0) begin
                for (int k = 0; k < INPUT_SZ; k++)
                    a_v[k] = alu_values[(NW-1-k)*16 +: 16];
            end else if (alu_load_enable == 2'd1) begin
                a_b = alu_values[79 -: 16];
                for (int k = 0; k < INPUT_SZ; k++)
                    a_w[k] = alu_values[(INPUT_SZ-1-k)*16 +: 16];
            end
        end
    end

    always_comb begin
        alu_acc = int'(a_b);
        for (int k = 0; k < INPUT_SZ; k++)
            alu_acc = alu_acc + ((int'(a_v[k]) * int'(a_w[k])) >>> 11);
        alu_value = alu_acc[15:0];
    end

    // Memory responder: one read in flight, latency fixed or random 1..5,
    // optionally followed by a garbage beat the DUT must ignore.
    initial begin
        logic [15:0] a;
        int lat;
        bit spur;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        spur = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = spur;
            if (spur) mem_rdata = 16'($urandom);
            spur = 1'b0;
            if (mem_rd) begin
                a = mem_addr;
                lat = lat_rand ? int'($urandom_range(1, 5)) : lat_fix;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    #1;
                    mem_rvalid = 1'b0;
                end
                mem_rvalid = 1'b1;
                mem_rdata = mem[a];
                spur = spur_en && ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Monitor
    initial begin
        logic [15:0] er;
        logic [7:0] ei;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (start && !busy) t_start = cyc;
                if (mem_rd) begin
                    rd_cnt++;
                    if (q_addr.size() > 0)
                        chk("rd_addr", mem_addr, q_addr.pop_front());
                    else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rd_extra: got read %h, want none", mem_addr);
                    end
                end
                if (alu_load_enable == 2'd0) begin
                    load0_cnt++;
                    if (q_vbus.size() > 0)
                        chk("value_bus", alu_values, q_vbus.pop_front());
                    else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL vload_extra: got %h, want none", alu_values);
                    end
                end
                if (alu_load_enable == 2'd1) load1_cnt++;
                if (result_valid) begin
                    if (q_res.size() > 0) begin
                        er = q_res.pop_front();
                        ei = q_idx.pop_front();
                        chk("result", result, er);
                        chk("result_idx", result_idx, ei);
                    end else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL result_extra: got %h idx %0d, want none",
                                 result, result_idx);
                    end
                end
                if (done) begin
                    done_cnt++;
                    t_done = cyc;
                end
            end
        end
    end

    function automatic logic [15:0] ref_neuron(input logic [15:0] vb,
                                               input logic [15:0] nb);
        int acc;
        acc = int'($signed(mem[nb]));
        for (int k = 0; k < INPUT_SZ; k++)
            acc += (int'($signed(mem[vb + 16'(k)])) *
                    int'($signed(mem[nb + 16'(k + 1)]))) >>> 11;
        return acc[15:0];
    endfunction

    task automatic expect_layer(input int nn, input logic [15:0] vb,
                                input logic [15:0] wb);
        for (int k = 0; k < INPUT_SZ; k++) q_addr.push_back(vb + 16'(k));
        q_vbus.push_back({mem[vb], mem[vb + 16'd1], mem[vb + 16'd2],
                          mem[vb + 16'd3], 16'h0000});
        for (int n = 0; n < nn; n++) begin
            for (int k = 0; k < NW; k++)
                q_addr.push_back(wb + 16'(n * NW + k));
            q_res.push_back(ref_neuron(vb, wb + 16'(n * NW)));
            q_idx.push_back(8'(n));
        end
    endtask

    task automatic pulse_start(input int nn, input logic [15:0] vb,
                               input logic [15:0] wb);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_neurons = 8'(nn);
        v_base = vb;
        w_base = wb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic fill_rand(input logic [15:0] vb, input logic [15:0] wb,
                             input int nn);
        for (int k = 0; k < INPUT_SZ; k++) mem[vb + 16'(k)] = 16'($urandom);
        for (int i = 0; i < nn * NW; i++) mem[wb + 16'(i)] = 16'($urandom);
    endtask

    task automatic run(input int nn, input logic [15:0] vb,
                       input logic [15:0] wb, input bit restart,
                       input bit check_lat);
        int d0, l0, l1, r0, c;
        expect_layer(nn, vb, wb);
        d0 = done_cnt;
        l0 = load0_cnt;
        l1 = load1_cnt;
        r0 = rd_cnt;
        pulse_start(nn, vb, wb);
        if (restart) begin
            repeat (6) @(posedge clk);
            pulse_start(nn + 2, vb + 16'h0040, wb + 16'h0040);
        end
        c = 0;
        while (done_cnt == d0 && c < 5000) begin
            @(posedge clk);
            c++;
        end
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: no done after %0d cycles", c);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("reads_left", q_addr.size(), 0);
        chk("results_left", q_res.size(), 0);
        chk("read_count", rd_cnt - r0, INPUT_SZ + NW * nn);
        chk("vload_cycles", load0_cnt - l0, 1);
        chk("wload_cycles", load1_cnt - l1, nn);
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_after", {alu_enable, busy}, 2'b00);
        if (check_lat)
            chk("latency", t_done - t_start,
                3 + INPUT_SZ * (lat_fix + 1) + nn * (NW * (lat_fix + 1) + 3));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c, nn;
        logic [15:0] vb, wb;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_load_en", alu_load_enable, 2'd2);
        chk("rst_busy", {alu_enable, busy}, 2'b00);
        chk("rst_strobes", {mem_rd, alu_clear, result_valid, done}, 4'h0);
        chk("rst_bus", alu_values, 80'h0);
        chk("rst_result", {result_idx, result, mem_addr}, 40'h0);
        rst_n = 1'b1;

        // single neuron: 1.0*1.0 + 2.0*1.0 + 0.5 = 3.5
        mem[16'h0100] = 16'h0800;
        mem[16'h0101] = 16'h1000;
        mem[16'h0102] = 16'h0000;
        mem[16'h0103] = 16'h0000;
        mem[16'h0200] = 16'h0400;
        mem[16'h0201] = 16'h0800;
        mem[16'h0202] = 16'h0800;
        mem[16'h0203] = 16'h0000;
        mem[16'h0204] = 16'h0000;
        run(1, 16'h0100, 16'h0200, 1'b0, 1'b1);
        chk("basic_value", result, 16'h1C00);

        // three neurons, bias only
        for (int n = 0; n < 3; n++)
            for (int k = 0; k < NW; k++)
                mem[16'h0300 + 16'(n * NW + k)] =
                    (k == 0) ? 16'(16'h0800 * (n + 1)) : 16'h0000;
        run(3, 16'h0100, 16'h0300, 1'b0, 1'b1);
        chk("bias_last", {result_idx, result}, 24'h02_1800);

        run(0, 16'h0100, 16'h0300, 1'b0, 1'b1);

        // variable latency with spurious beats
        lat_rand = 1'b1;
        spur_en = 1'b1;
        run(3, 16'h0100, 16'h0300, 1'b0, 1'b0);
        run(1, 16'h0100, 16'h0200, 1'b0, 1'b0);
        chk("basic_var_lat", result, 16'h1C00);

        for (int r = 0; r < 4; r++) begin
            nn = int'($urandom_range(1, 6));
            vb = 16'($urandom);
            wb = (r == 2) ? 16'hFFF8 : 16'($urandom);
            fill_rand(vb, wb, nn);
            run(nn, vb, wb, r == 1, 1'b0);
        end

        // start pulsed again while busy
        lat_rand = 1'b0;
        spur_en = 1'b0;
        lat_fix = 1;
        run(3, 16'h0100, 16'h0300, 1'b1, 1'b1);

        // reset while waiting for neuron 1's bias word
        lat_rand = 1'b1;
        fill_rand(16'h0500, 16'h0600, 3);
        expect_layer(3, 16'h0500, 16'h0600);
        d0 = done_cnt;
        pulse_start(3, 16'h0500, 16'h0600);
        c = 0;
        while (!(mem_rd && mem_addr == 16'h0605) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("reach_n1_read", mem_addr, 16'h0605);
        @(posedge clk);
        #2;
        chk("busy_mid", {alu_enable, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_load_en", alu_load_enable, 2'd2);
        chk("mid_rst_busy", {alu_enable, busy}, 2'b00);
        chk("mid_rst_strobes", {mem_rd, alu_clear, result_valid, done}, 4'h0);
        q_addr.delete();
        q_res.delete();
        q_idx.delete();
        q_vbus.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        lat_rand = 1'b0;
        lat_fix = 2;
        run(3, 16'h0500, 16'h0600, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
